// File: rtl/eq_req_arbiter_if.sv
// Request/datapath/response bundle for eq_req_arbiter. The slave modport is the
// arbiter's view; master is the view of the clients plus the datapath instance.
interface eq_req_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int QW  = 2 * WIDTH + 4;

  logic                     en_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_a_i;
  logic [NUM_REQ*WIDTH-1:0] req_b_i;
  logic [NUM_REQ*WIDTH-1:0] req_c_i;
  logic [NUM_REQ*WIDTH-1:0] req_d_i;
  logic                     dp_valid_o;
  logic [WIDTH-1:0]         dp_a_o;
  logic [WIDTH-1:0]         dp_b_o;
  logic [WIDTH-1:0]         dp_c_o;
  logic [WIDTH-1:0]         dp_d_o;
  logic                     dp_valid_i;
  logic [QW-1:0]            dp_q_i;
  logic                     rsp_valid_o;
  logic [IDW-1:0]           rsp_id_o;
  logic [QW-1:0]            rsp_q_o;
  logic                     busy_o;
  logic                     err_o;

  // Handshake: a request transfers in any cycle where req_valid_i[i] and
  // req_ready_o[i] are both high; ready is at most one-hot and never waits on valid
  // from the datapath side.
  modport slave (
    input  en_i, req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i, dp_valid_i, dp_q_i,
    output req_ready_o, dp_valid_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o,
    output rsp_valid_o, rsp_id_o, rsp_q_o, busy_o, err_o
  );

  modport master (
    output en_i, req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i, dp_valid_i, dp_q_i,
    input  req_ready_o, dp_valid_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o,
    input  rsp_valid_o, rsp_id_o, rsp_q_o, busy_o, err_o
  );
endinterface

// File: rtl/eq_req_arbiter.sv
// Round-robin front end sharing one equation datapath between NUM_REQ clients;
// a tag pipe matched to the datapath latency routes each result back to its client.
module eq_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input logic              clk,
  input logic              rst,
  eq_req_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int QW  = 2 * WIDTH + 4;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_id, idx_c;
  logic               grant_vld;
  logic [NUM_REQ-1:0] ready;
  logic               xfer;
  logic [WIDTH-1:0]   sel_a, sel_b, sel_c, sel_d;

  logic               dp_valid_q;
  logic [WIDTH-1:0]   dp_a_q, dp_b_q, dp_c_q, dp_d_q;
  logic [IDW-1:0]     issue_id_q;

  logic [LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];

  logic               rsp_fire;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [QW-1:0]      rsp_q_q;
  logic               err_q;

  // Search starts just above the last winner so every client gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx_c     = '0;
    ready     = '0;
    if (bus.en_i) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx_c = IDW'((int'(ptr_q) + k) % NUM_REQ);
        if (!grant_vld && bus.req_valid_i[idx_c]) begin
          grant_vld = 1'b1;
          grant_id  = idx_c;
        end
      end
    end
    if (grant_vld) ready[grant_id] = 1'b1;
  end

  always_comb begin
    xfer  = |(ready & bus.req_valid_i);
    ptr_d = xfer ? grant_id : ptr_q;
    sel_a = bus.req_a_i[int'(grant_id)*WIDTH +: WIDTH];
    sel_b = bus.req_b_i[int'(grant_id)*WIDTH +: WIDTH];
    sel_c = bus.req_c_i[int'(grant_id)*WIDTH +: WIDTH];
    sel_d = bus.req_d_i[int'(grant_id)*WIDTH +: WIDTH];
    rsp_fire = bus.dp_valid_i & tag_v_q[LATENCY-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= IDW'(NUM_REQ - 1);
      dp_valid_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_c_q      <= '0;
      dp_d_q      <= '0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      dp_valid_q <= xfer;
      if (xfer) begin
        dp_a_q     <= sel_a;
        dp_b_q     <= sel_b;
        dp_c_q     <= sel_c;
        dp_d_q     <= sel_d;
        issue_id_q <= grant_id;
      end
      // Stage 0 follows the issue register, so the last stage lines up with dp_valid_i.
      tag_v_q[0]  <= dp_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_id_q <= tag_id_q[LATENCY-1];
        rsp_q_q  <= bus.dp_q_i;
      end
      if (bus.dp_valid_i != tag_v_q[LATENCY-1]) err_q <= 1'b1;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.dp_valid_o  = dp_valid_q;
  assign bus.dp_a_o      = dp_a_q;
  assign bus.dp_b_o      = dp_b_q;
  assign bus.dp_c_o      = dp_c_q;
  assign bus.dp_d_o      = dp_d_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_q_o     = rsp_q_q;
  assign bus.busy_o      = dp_valid_q | (|tag_v_q) | rsp_valid_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_eq_req_arbiter.sv
// Directed bench for eq_req_arbiter with a 3-stage behavioural datapath model
// sharing the arbiter's reset.
module tb_eq_req_arbiter;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 3;
  localparam int QW      = 2 * WIDTH + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  eq_req_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  eq_req_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [QW-1:0] eq_model(input logic [WIDTH-1:0] a, b, c, d);
    int r;
    r = ((1 + 3 * int'($signed(c))) * (int'($signed(a)) - int'($signed(b)))
         - 4 * int'($signed(d))) / 2;
    return r[QW-1:0];
  endfunction

  // Datapath stand-in; inject forces a stray valid onto its output.
  logic [2:0]    m_v;
  logic [QW-1:0] m_q [3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= '0;
      for (int i = 0; i < 3; i++) m_q[i] <= '0;
    end else begin
      m_v    <= {m_v[1:0], bus.dp_valid_o};
      m_q[0] <= eq_model(bus.dp_a_o, bus.dp_b_o, bus.dp_c_o, bus.dp_d_o);
      m_q[1] <= m_q[0];
      m_q[2] <= m_q[1];
    end
  end
  assign bus.dp_valid_i = m_v[2] | inject;
  assign bus.dp_q_i     = m_q[2];

  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    got_id [$];
  logic [QW-1:0] got_q  [$];
  int            got_cyc[$];
  always @(negedge clk) begin
    if (bus.rsp_valid_o === 1'b1) begin
      got_id.push_back(bus.rsp_id_o);
      got_q.push_back(bus.rsp_q_o);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    got_id.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.en_i = 1'b1;
    inject = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_reset();
    bus.en_i = 1'b1;
    bus.req_valid_i = '0;
    bus.req_a_i = '0; bus.req_b_i = '0; bus.req_c_i = '0; bus.req_d_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.dp_valid_o !== 1'b0) $display("FAIL reset_dp_valid: got %0b want 0", bus.dp_valid_o); else passed++;
    total++; if (bus.dp_a_o !== 8'h00) $display("FAIL reset_dp_a: got %0h want 0", bus.dp_a_o); else passed++;
    total++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid_o); else passed++;
    total++; if (bus.rsp_id_o !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id_o); else passed++;
    total++; if (bus.rsp_q_o !== 20'd0) $display("FAIL reset_rsp_q: got %0h want 0", bus.rsp_q_o); else passed++;
    total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err: got %0b want 0", bus.err_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy_o); else passed++;
    rst = 1'b0;
    bus.req_valid_i = 4'b1111;
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready_o); else passed++;
    bus.req_valid_i = '0;
  endtask

  task automatic test_single_op();
    int n;
    do_reset();
    bus.req_a_i[16 +: 8] = 8'd5;
    bus.req_b_i[16 +: 8] = 8'd2;
    bus.req_c_i[16 +: 8] = 8'd1;
    bus.req_d_i[16 +: 8] = 8'd1;
    bus.req_valid_i = 4'b0100;
    #1;
    total++; if (bus.req_ready_o !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus.req_ready_o); else passed++;
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.dp_valid_o !== 1'b1) $display("FAIL single_dp_valid: got %0b want 1", bus.dp_valid_o); else passed++;
    total++; if ({bus.dp_a_o, bus.dp_b_o, bus.dp_c_o, bus.dp_d_o} !== 32'h05020101)
      $display("FAIL single_dp_ops: got %h want 05020101", {bus.dp_a_o, bus.dp_b_o, bus.dp_c_o, bus.dp_d_o}); else passed++;
    total++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy: got %0b want 1", bus.busy_o); else passed++;
    n = 1;
    while (bus.rsp_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != 5) $display("FAIL single_latency: got %0d want 5", n); else passed++;
    total++; if (bus.rsp_id_o !== 2'd2) $display("FAIL single_id: got %0d want 2", bus.rsp_id_o); else passed++;
    total++; if (bus.rsp_q_o !== 20'd4) $display("FAIL single_q: got %0d want 4", bus.rsp_q_o); else passed++;
    @(negedge clk);
    total++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL single_pulse: got %0b want 0", bus.rsp_valid_o); else passed++;
    total++; if (bus.rsp_id_o !== 2'd2) $display("FAIL single_id_hold: got %0d want 2", bus.rsp_id_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL single_busy_end: got %0b want 0", bus.busy_o); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a_i[i*8 +: 8] = 8'(2 * (i + 1));
      bus.req_b_i[i*8 +: 8] = 8'd0;
      bus.req_c_i[i*8 +: 8] = 8'd0;
      bus.req_d_i[i*8 +: 8] = 8'd0;
    end
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      total++; if (bus.req_ready_o !== exp_rdy) $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready_o, exp_rdy); else passed++;
      @(negedge clk);
    end
    bus.req_valid_i = '0;
    repeat (8) @(negedge clk);
    total++; if (got_id.size() != 8) $display("FAIL rr_count: got %0d want 8", got_id.size()); else passed++;
    for (int k = 0; k < got_id.size() && k < 8; k++) begin
      total++; if (got_id[k] !== 2'(k % 4)) $display("FAIL rr_id%0d: got %0d want %0d", k, got_id[k], k % 4); else passed++;
      total++; if (got_q[k] !== 20'(k % 4 + 1)) $display("FAIL rr_q%0d: got %0d want %0d", k, got_q[k], k % 4 + 1); else passed++;
      if (k > 0) begin
        total++; if (got_cyc[k] != got_cyc[k-1] + 1) $display("FAIL rr_b2b%0d: got cycle %0d want %0d", k, got_cyc[k], got_cyc[k-1] + 1); else passed++;
      end
    end
  endtask

  task automatic test_negative();
    int n;
    @(negedge clk);
    clear_q();
    bus.req_a_i[8 +: 8] = 8'h80;
    bus.req_b_i[8 +: 8] = 8'h7f;
    bus.req_c_i[8 +: 8] = 8'h80;
    bus.req_d_i[8 +: 8] = 8'h80;
    bus.req_valid_i = 4'b0010;
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.dp_c_o !== 8'h80) $display("FAIL neg_dp_c: got %h want 80", bus.dp_c_o); else passed++;
    n = 1;
    while (bus.rsp_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (bus.rsp_valid_o !== 1'b1) $display("FAIL neg_timeout: got %0b want 1", bus.rsp_valid_o); else passed++;
    // (1-384)*(-255)+512 = 98177; halved toward zero = 49088
    total++; if (bus.rsp_q_o !== 20'd49088) $display("FAIL neg_q: got %0d want 49088", bus.rsp_q_o); else passed++;
    total++; if (bus.rsp_id_o !== 2'd1) $display("FAIL neg_id: got %0d want 1", bus.rsp_id_o); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable();
    int n;
    int bad_ready;
    do_reset();
    bus.req_valid_i = 4'b1000;
    #1;
    total++; if (bus.req_ready_o !== 4'b1000) $display("FAIL en_first: got %b want 1000", bus.req_ready_o); else passed++;
    @(negedge clk);
    bus.req_valid_i = 4'b0001;
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL en_second: got %b want 0001", bus.req_ready_o); else passed++;
    @(negedge clk);
    bus.en_i = 1'b0;
    bus.req_valid_i = 4'b1010;
    n = 0;
    bad_ready = 0;
    #1;
    while (bus.busy_o === 1'b1 && n < 20) begin
      if (bus.req_ready_o !== 4'b0000) bad_ready++;
      @(negedge clk);
      #1;
      n++;
    end
    total++; if (bad_ready != 0) $display("FAIL en_ready_blocked: got %0d grants want 0", bad_ready); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL en_busy_fall: got %0b want 0", bus.busy_o); else passed++;
    total++; if (got_id.size() != 2) $display("FAIL en_rsp_count: got %0d want 2", got_id.size()); else passed++;
    if (got_id.size() == 2) begin
      total++; if (got_id[0] !== 2'd3 || got_id[1] !== 2'd0) $display("FAIL en_rsp_ids: got %0d,%0d want 3,0", got_id[0], got_id[1]); else passed++;
    end
    bus.en_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 4'b0010) $display("FAIL en_resume1: got %b want 0010", bus.req_ready_o); else passed++;
    @(negedge clk);
    #1;
    total++; if (bus.req_ready_o !== 4'b1000) $display("FAIL en_resume3: got %b want 1000", bus.req_ready_o); else passed++;
    bus.req_valid_i = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_mismatch();
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    total++; if (bus.err_o !== 1'b1) $display("FAIL mm_err_set: got %0b want 1", bus.err_o); else passed++;
    total++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL mm_no_rsp: got %0b want 0", bus.rsp_valid_o); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.err_o !== 1'b1) $display("FAIL mm_err_sticky: got %0b want 1", bus.err_o); else passed++;
    total++; if (got_id.size() != 0) $display("FAIL mm_rsp_count: got %0d want 0", got_id.size()); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.err_o !== 1'b0) $display("FAIL mm_err_clear: got %0b want 0", bus.err_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.req_valid_i = 4'b0111;
    repeat (3) @(negedge clk);
    bus.req_valid_i = '0;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b1) $display("FAIL rm_busy_before: got %0b want 1", bus.busy_o); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.dp_valid_o !== 1'b0) $display("FAIL rm_dp_valid: got %0b want 0", bus.dp_valid_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rm_busy: got %0b want 0", bus.busy_o); else passed++;
    total++; if (bus.dp_a_o !== 8'h00) $display("FAIL rm_dp_a: got %h want 00", bus.dp_a_o); else passed++;
    clear_q();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (got_id.size() != 0) $display("FAIL rm_no_rsp: got %0d want 0", got_id.size()); else passed++;
    total++; if (bus.err_o !== 1'b0) $display("FAIL rm_err: got %0b want 0", bus.err_o); else passed++;
    bus.req_valid_i = 4'b1111;
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL rm_first_grant: got %b want 0001", bus.req_ready_o); else passed++;
    bus.req_valid_i = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_negative();
    test_enable();
    test_mismatch();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
